// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register stage: state encoding and default payload widths.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        SKIDFULL = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with an optional skid entry; flush squashes all held entries.
// Latency: one register (accept at edge N is visible after edge N). Backpressure: in_ready registered when SKID=1, combinational when SKID=0.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    stage_state_t      state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              rdy_q;
    logic              accept;
    logic              retire;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;

    // Flush forces in_ready high so upstream never sees a stall on a squash cycle.
    assign in_ready = flush | ((SKID != 0) ? rdy_q : (!out_valid | out_ready));

    // The payload offered during a flush is dropped, so it does not count as accepted.
    assign accept = in_valid & in_ready & !flush;
    assign retire = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            FULL:     occupancy = 2'd1;
            SKIDFULL: occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            rdy_q     <= 1'b1;
        end else if (flush) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end
                end
                FULL: begin
                    if (retire && accept) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (retire) begin
                        state <= EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        state     <= SKIDFULL;
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        rdy_q     <= 1'b0;
                    end
                end
                SKIDFULL: begin
                    // Skid entry moves up only once main has retired, preserving order.
                    if (retire) begin
                        state     <= FULL;
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        rdy_q     <= 1'b1;
                    end
                end
                default: begin
                    state <= EMPTY;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

    a_bubble_nop: assert property (@(posedge clk) disable iff (reset)
        !out_valid |-> (out_ctrl == '0));

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_data) && $stable(out_ctrl)));

    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        occupancy <= ((SKID != 0) ? 2'd2 : 2'd1));

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: one instance with the skid entry, one without, sharing stimulus.
module tb_pipe_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1;
    logic [31:0] out_data1;
    logic [7:0]  out_ctrl1;
    logic [1:0]  occupancy1;

    logic        in_ready0, out_valid0;
    logic [31:0] out_data0;
    logic [7:0]  out_ctrl0;
    logic [1:0]  occupancy0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_dut_skid (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1),
        .occupancy(occupancy1)
    );

    pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_dut_noskid (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .occupancy(occupancy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        check("rst_out_ctrl", {24'd0, out_ctrl1}, 32'd0);
        check("rst_occ", {30'd0, occupancy1}, 32'd0);
        tick(); tick();
        reset = 1'b0;

        // Streaming 1..4 with no backpressure
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = i; in_ctrl = 8'h10 + 8'(i);
            #1;
            check("str_in_ready", {31'd0, in_ready1}, 32'd1);
            tick();
            check("str_out_valid", {31'd0, out_valid1}, 32'd1);
            check("str_out_data", out_data1, i);
            check("str_out_ctrl", {24'd0, out_ctrl1}, 32'h10 + i);
            check("str_occ", {30'd0, occupancy1}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("str_drain_valid", {31'd0, out_valid1}, 32'd0);
        check("str_drain_ctrl", {24'd0, out_ctrl1}, 32'd0);

        // Stall with skid: A held, B in skid, C waits upstream
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'hAA;
        tick();
        check("stl_a_data", out_data1, 32'hA);
        check("stl_a_occ", {30'd0, occupancy1}, 32'd1);
        check("stl_a_rdy", {31'd0, in_ready1}, 32'd1);
        in_data = 32'hB; in_ctrl = 8'hBB;
        tick();
        check("stl_b_occ", {30'd0, occupancy1}, 32'd2);
        check("stl_b_rdy", {31'd0, in_ready1}, 32'd0);
        check("stl_b_data", out_data1, 32'hA);
        in_data = 32'hC; in_ctrl = 8'hCC;
        tick();
        check("stl_c_held_occ", {30'd0, occupancy1}, 32'd2);
        check("stl_c_held_data", out_data1, 32'hA);
        check("stl_c_held_ctrl", {24'd0, out_ctrl1}, 32'hAA);
        out_ready = 1'b1;
        tick();
        check("rel_b_data", out_data1, 32'hB);
        check("rel_b_occ", {30'd0, occupancy1}, 32'd1);
        check("rel_b_rdy", {31'd0, in_ready1}, 32'd1);
        tick();
        check("rel_c_data", out_data1, 32'hC);
        check("rel_c_ctrl", {24'd0, out_ctrl1}, 32'hCC);
        in_valid = 1'b0;
        tick();
        check("rel_empty", {31'd0, out_valid1}, 32'd0);

        // Flush while SKIDFULL, offering 0xD in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1; in_ctrl = 8'h21;
        tick();
        in_data = 32'h2; in_ctrl = 8'h22;
        tick();
        check("fl_pre_occ", {30'd0, occupancy1}, 32'd2);
        flush = 1'b1; in_data = 32'hD; in_ctrl = 8'hDD;
        #1;
        check("fl_in_ready", {31'd0, in_ready1}, 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid1}, 32'd0);
        check("fl_out_ctrl", {24'd0, out_ctrl1}, 32'd0);
        check("fl_occ", {30'd0, occupancy1}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("fl_no_d", {31'd0, out_valid1}, 32'd0);
        end

        // SKID=0: combinational in_ready, same-cycle retire+accept
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h07;
        #1;
        check("ns_empty_rdy", {31'd0, in_ready0}, 32'd1);
        tick();
        check("ns_full_rdy", {31'd0, in_ready0}, 32'd0);
        check("ns_full_occ", {30'd0, occupancy0}, 32'd1);
        in_data = 32'h78; in_ctrl = 8'h08;
        tick();
        check("ns_stall_data", out_data0, 32'h77);
        out_ready = 1'b1;
        #1;
        check("ns_release_rdy", {31'd0, in_ready0}, 32'd1);
        tick();
        check("ns_swap_data", out_data0, 32'h78);
        check("ns_swap_occ", {30'd0, occupancy0}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("ns_drain_occ", {30'd0, occupancy0}, 32'd0);

        // Async reset mid-cycle while FULL with ctrl 0xFF
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'hFF;
        tick();
        in_valid = 1'b0;
        check("ar_pre_ctrl", {24'd0, out_ctrl1}, 32'hFF);
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_valid", {31'd0, out_valid1}, 32'd0);
        check("ar_out_ctrl", {24'd0, out_ctrl1}, 32'd0);
        check("ar_in_ready", {31'd0, in_ready1}, 32'd1);
        check("ar_occ", {30'd0, occupancy1}, 32'd0);
        check("ar_ns_valid", {31'd0, out_valid0}, 32'd0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("ar_abandoned", {31'd0, out_valid1}, 32'd0);
        check("ar_rdy_after", {31'd0, in_ready1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
